// File: rtl/multi_button_control.sv
// N-button vote pulser: synchronise, qualify a single held button,
// emit one vote pulse per press, reject multi-button presses.
module multi_button_control #(
  parameter int NUM_BUTTONS = 4,
  parameter int HOLD_CYCLES = 100,
  parameter int CNT_W       = 8,
  parameter int IDX_W       = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] button,
  input  logic                   mode,
  output logic [NUM_BUTTONS-1:0] vote,
  output logic                   vote_valid,
  output logic [IDX_W-1:0]       vote_index,
  output logic                   busy,
  output logic                   conflict
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT_RELEASE,
    LOCKOUT
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [NUM_BUTTONS-1:0] ONE = NUM_BUTTONS'(1);

  state_t state, state_n;

  logic [NUM_BUTTONS-1:0] sync1, s;
  logic [NUM_BUTTONS-1:0] sel, sel_n;
  logic [NUM_BUTTONS-1:0] vote_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [IDX_W-1:0]       enc, idx_n;
  logic                   vv_n, conf_n;
  logic                   any, one_hot;

  // two-flop synchroniser for the raw button levels
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= button;
      s     <= sync1;
    end
  end

  // press classification of the synchronised levels
  always_comb begin
    any     = |s;
    one_hot = any && ((s & (s - ONE)) == '0);
  end

  // binary index of the latched candidate
  always_comb begin
    enc = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (sel[i]) enc = enc | IDX_W'(i);
    end
  end

  // next state, hold counter and registered output values
  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    vote_n  = '0;
    vv_n    = 1'b0;
    idx_n   = '0;
    conf_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!mode && one_hot) begin
          state_n = HOLD;
          sel_n   = s;
          cnt_n   = CNT_W'(1);
        end else if (!mode && any) begin
          state_n = LOCKOUT;
          conf_n  = 1'b1;
        end
      end
      HOLD: begin
        if (mode) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if ((s & ~sel) != '0) begin
          // a second button beats completion
          state_n = LOCKOUT;
          cnt_n   = '0;
          conf_n  = 1'b1;
        end else if ((s & sel) == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = WAIT_RELEASE;
          cnt_n   = '0;
          vote_n  = sel;
          vv_n    = 1'b1;
          idx_n   = enc;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (!any) state_n = IDLE;
      end
      LOCKOUT: begin
        if (!any) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // state, counter, latched selection and output pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= '0;
      vote       <= '0;
      vote_valid <= 1'b0;
      vote_index <= '0;
      conflict   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      vote       <= vote_n;
      vote_valid <= vv_n;
      vote_index <= idx_n;
      conflict   <= conf_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_multi_button_control.sv
// Bench for multi_button_control: vector table plus event
// scoreboard with exact pulse timing.
module tb_multi_button_control;

  localparam int H = 100;

  logic       clock, reset_n, mode;
  logic [3:0] button, vote;
  logic [1:0] vote_index;
  logic       vote_valid, busy, conflict;

  int tests, fails, cyc;

  typedef struct {
    logic [3:0] btn;
    int         len;
    logic       ev_vote;
    logic       ev_conf;
    logic [1:0] idx;
  } vec_t;

  typedef struct {
    logic       is_vote;
    logic [3:0] v;
    logic [1:0] idx;
    int         at;
  } ev_t;

  ev_t  sb[$];
  vec_t vecs[9];

  multi_button_control #(
    .NUM_BUTTONS(4),
    .HOLD_CYCLES(H),
    .CNT_W(8),
    .IDX_W(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .button(button),
    .mode(mode),
    .vote(vote),
    .vote_valid(vote_valid),
    .vote_index(vote_index),
    .busy(busy),
    .conflict(conflict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push_vote(logic [3:0] b, logic [1:0] i,
                           int at);
    sb.push_back('{1'b1, b, i, at});
  endtask

  task automatic push_conf(int at);
    sb.push_back('{1'b0, 4'b0, 2'd0, at});
  endtask

  task automatic apply(vec_t v);
    int n;
    n = cyc;
    button = v.btn;
    if (v.ev_vote) push_vote(v.btn, v.idx, n + H + 2);
    if (v.ev_conf) push_conf(n + 3);
    repeat (v.len) @(negedge clock);
    button = '0;
    repeat (8) @(negedge clock);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        check("inv_valid", 32'(vote_valid), 32'(|vote));
        check("inv_excl", 32'(vote_valid & conflict), 0);
        if (!vote_valid) check("inv_idx", 32'(vote_index), 0);
        if (vote_valid || conflict) begin
          if (sb.size() == 0) begin
            check("unexpected_event",
                  {30'd0, vote_valid, conflict}, 0);
          end else begin
            e = sb.pop_front();
            check("ev_kind", 32'(vote_valid), 32'(e.is_vote));
            check("ev_vote", 32'(vote), 32'(e.v));
            check("ev_idx", 32'(vote_index), 32'(e.idx));
            check("ev_cycle", cyc, e.at);
          end
        end
      end
    end
  endtask

  initial begin
    int n, r;
    logic bad;
    vecs[0] = '{4'b0010, 100, 1'b1, 1'b0, 2'd1};
    vecs[1] = '{4'b0001,  99, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{4'b0001, 100, 1'b1, 1'b0, 2'd0};
    vecs[3] = '{4'b0100, 500, 1'b1, 1'b0, 2'd2};
    vecs[4] = '{4'b0100, 100, 1'b1, 1'b0, 2'd2};
    vecs[5] = '{4'b0011,  20, 1'b0, 1'b1, 2'd0};
    vecs[6] = '{4'b1000, 100, 1'b1, 1'b0, 2'd3};
    vecs[7] = '{4'b1111,  10, 1'b0, 1'b1, 2'd0};
    vecs[8] = '{4'b0001,   1, 1'b0, 1'b0, 2'd0};

    tests = 0;
    fails = 0;
    cyc = 0;
    reset_n = 1'b0;
    button = '0;
    mode = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_vote", 32'(vote), 0);
    check("rst_valid", 32'(vote_valid), 0);
    check("rst_idx", 32'(vote_index), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_conf", 32'(conflict), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    fork
      monitor();
    join_none

    foreach (vecs[i]) apply(vecs[i]);

    // busy timing around a full press and release
    n = cyc;
    button = 4'b0010;
    push_vote(4'b0010, 2'd1, n + H + 2);
    repeat (50) @(negedge clock);
    check("busy_mid", 32'(busy), 1);
    repeat (60) @(negedge clock);
    button = '0;
    r = cyc;
    repeat (2) @(negedge clock);
    check("busy_rel2", 32'(busy), 1);
    @(negedge clock);
    check("busy_rel3", 32'(busy), 0);
    repeat (5) @(negedge clock);

    // second button joins during hold
    button = 4'b1000;
    repeat (50) @(negedge clock);
    button = 4'b1001;
    n = cyc;
    push_conf(n + 3);
    repeat (20) @(negedge clock);
    check("lockout_busy", 32'(busy), 1);
    button = '0;
    repeat (8) @(negedge clock);

    // display mode ignores buttons
    mode = 1'b1;
    button = 4'b0001;
    bad = 1'b0;
    repeat (200) begin
      @(negedge clock);
      if (busy) bad = 1'b1;
    end
    check("mode1_busy", 32'(bad), 0);
    button = '0;
    repeat (5) @(negedge clock);
    mode = 1'b0;
    repeat (3) @(negedge clock);

    // mode switch aborts an ongoing hold
    button = 4'b0001;
    repeat (60) @(negedge clock);
    check("abort_busy_pre", 32'(busy), 1);
    mode = 1'b1;
    repeat (140) @(negedge clock);
    check("abort_busy_post", 32'(busy), 0);
    button = '0;
    repeat (5) @(negedge clock);
    mode = 1'b0;
    repeat (3) @(negedge clock);

    // asynchronous reset in the middle of a hold
    button = 4'b0010;
    repeat (70) @(negedge clock);
    check("rst_mid_busy_pre", 32'(busy), 1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_valid", 32'(vote_valid), 0);
    check("rst_mid_vote", 32'(vote), 0);
    button = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    apply('{4'b0010, 100, 1'b1, 1'b0, 2'd1});
    apply('{4'b0100,  99, 1'b0, 1'b0, 2'd0});

    repeat (20) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
